// File: rtl/imem_loader_pkg.sv
// Shared types for the UART instruction-memory loader: FSM states, error codes
// and the frame sync byte.
package imem_loader_pkg;

   typedef enum logic [2:0] {
      IDLE,
      WAIT_SYNC,
      LEN_LO,
      LEN_HI,
      DATA,
      CSUM,
      DONE,
      ERROR
   } loader_state_e;

   typedef enum logic [1:0] {
      ERR_NONE    = 2'd0,
      ERR_LENGTH  = 2'd1,
      ERR_CSUM    = 2'd2,
      ERR_TIMEOUT = 2'd3
   } err_code_e;

   localparam logic [7:0] SYNC_BYTE = 8'hA5;

endpackage

// File: rtl/imem_uart_loader.sv
// Boot loader: frames the UART byte stream, assembles little-endian words,
// writes them to instruction memory and releases the core after a verified load.
module imem_uart_loader
   import imem_loader_pkg::*;
#(
   parameter int unsigned DEPTH          = 30,
   parameter logic [31:0] BASE_ADDR      = 32'h8000_0000,
   parameter int unsigned TIMEOUT_CYCLES = 1000000
)(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        busy,
   output logic        done,
   output logic        error,
   output logic [1:0]  err_code,
   output logic [15:0] words_loaded,
   output logic        core_hold
);

   localparam int            TW        = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] TMO_LIMIT = TW'(TIMEOUT_CYCLES);

   loader_state_e r_state;
   logic          r_we;
   logic [31:0]   r_addr;
   logic [31:0]   r_wdata;
   logic          r_busy;
   logic          r_done;
   logic          r_error;
   err_code_e     r_err_code;
   logic [15:0]   r_idx;
   logic [15:0]   r_len;
   logic [7:0]    r_len_lo;
   logic [7:0]    r_csum;
   logic [23:0]   r_asm;
   logic [1:0]    r_bcnt;
   logic [TW-1:0] r_tmo;
   logic          r_core_hold;

   logic          w_receiving;
   logic          w_accept;
   logic [15:0]   w_len;
   logic [15:0]   w_idx_inc;
   logic [TW-1:0] w_tmo_inc;
   logic          w_tmo_hit;

   assign w_receiving = r_state inside {WAIT_SYNC, LEN_LO, LEN_HI, DATA, CSUM};
   assign w_accept    = rx_valid & ~start & w_receiving;
   assign w_len       = {rx_data, r_len_lo};
   assign w_idx_inc   = r_idx + 16'd1;
   assign w_tmo_inc   = r_tmo + TW'(1);
   assign w_tmo_hit   = (w_tmo_inc == TMO_LIMIT);

   // r_tmo holds the idle count of the cycle now running; the accepting cycle is count 0
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_we        <= 1'b0;
         r_addr      <= BASE_ADDR;
         r_wdata     <= '0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_error     <= 1'b0;
         r_err_code  <= ERR_NONE;
         r_idx       <= '0;
         r_len       <= '0;
         r_len_lo    <= '0;
         r_csum      <= '0;
         r_asm       <= '0;
         r_bcnt      <= '0;
         r_tmo       <= '0;
         r_core_hold <= 1'b1;
      end else begin
         r_we <= 1'b0;
         case (r_state)
            IDLE, DONE, ERROR: begin
               r_tmo <= '0;
               if (start) begin
                  r_state     <= WAIT_SYNC;
                  r_busy      <= 1'b1;
                  r_done      <= 1'b0;
                  r_error     <= 1'b0;
                  r_err_code  <= ERR_NONE;
                  r_idx       <= '0;
                  r_csum      <= '0;
                  r_bcnt      <= '0;
                  r_core_hold <= 1'b1;
               end
            end
            WAIT_SYNC: begin
               if (w_accept && rx_data == SYNC_BYTE) begin
                  r_state <= LEN_LO;
                  r_tmo   <= TW'(1);
               end
            end
            default: begin
               if (w_accept) begin
                  r_tmo <= TW'(1);
                  case (r_state)
                     LEN_LO: begin
                        r_len_lo <= rx_data;
                        r_state  <= LEN_HI;
                     end
                     LEN_HI: begin
                        r_len <= w_len;
                        if (32'(w_len) > DEPTH) begin
                           r_state    <= ERROR;
                           r_error    <= 1'b1;
                           r_err_code <= ERR_LENGTH;
                           r_busy     <= 1'b0;
                        end else if (w_len == 16'd0) begin
                           r_state <= CSUM;
                        end else begin
                           r_state <= DATA;
                        end
                     end
                     DATA: begin
                        r_csum <= r_csum ^ rx_data;
                        r_asm  <= {rx_data, r_asm[23:8]};
                        r_bcnt <= r_bcnt + 2'd1;
                        if (r_bcnt == 2'd3) begin
                           r_we    <= 1'b1;
                           r_wdata <= {rx_data, r_asm};
                           r_addr  <= BASE_ADDR + {14'd0, r_idx, 2'b00};
                           r_idx   <= w_idx_inc;
                           if (w_idx_inc == r_len)
                              r_state <= CSUM;
                        end
                     end
                     default: begin
                        r_busy <= 1'b0;
                        if (rx_data == r_csum) begin
                           r_state     <= DONE;
                           r_done      <= 1'b1;
                           r_core_hold <= 1'b0;
                        end else begin
                           r_state    <= ERROR;
                           r_error    <= 1'b1;
                           r_err_code <= ERR_CSUM;
                        end
                     end
                  endcase
               end else begin
                  r_tmo <= w_tmo_inc;
                  if (w_tmo_hit) begin
                     r_state    <= ERROR;
                     r_error    <= 1'b1;
                     r_err_code <= ERR_TIMEOUT;
                     r_busy     <= 1'b0;
                  end
               end
            end
         endcase
      end
   end

   assign mem_we       = r_we;
   assign mem_addr     = r_addr;
   assign mem_wdata    = r_wdata;
   assign busy         = r_busy;
   assign done         = r_done;
   assign error        = r_error;
   assign err_code     = r_err_code;
   assign words_loaded = r_idx;
   assign core_hold    = r_core_hold;

endmodule

// File: tb/tb_imem_uart_loader.sv
// Bench for imem_uart_loader: directed frames plus random frames checked
// against a frame-parsing reference model.
module tb_imem_uart_loader;

   localparam int          DEPTH = 30;
   localparam logic [31:0] BASE  = 32'h8000_0000;
   localparam int          TMO   = 100;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [7:0]  rx_data = 8'h00;
   logic        rx_valid = 1'b0;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        busy;
   logic        done;
   logic        error;
   logic [1:0]  err_code;
   logic [15:0] words_loaded;
   logic        core_hold;

   imem_uart_loader #(
      .DEPTH(DEPTH),
      .BASE_ADDR(BASE),
      .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .start(start),
      .rx_data(rx_data),
      .rx_valid(rx_valid),
      .mem_we(mem_we),
      .mem_addr(mem_addr),
      .mem_wdata(mem_wdata),
      .busy(busy),
      .done(done),
      .error(error),
      .err_code(err_code),
      .words_loaded(words_loaded),
      .core_hold(core_hold)
   );

   always #5 clk = ~clk;

   int          n_vec = 0;
   int          n_err = 0;
   logic [31:0] cap_addr[$];
   logic [31:0] cap_data[$];
   logic [31:0] exp_addr[$];
   logic [31:0] exp_data[$];
   bit          exp_done;
   logic [1:0]  exp_code;
   logic [7:0]  frm[$];
   logic        prev_we = 1'b0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      rx_data  = b;
      rx_valid = 1'b1;
      tick();
      rx_valid = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // Write monitor: records every write and its word count
   always @(negedge clk) begin
      if (mem_we === 1'b1) begin
         cap_addr.push_back(mem_addr);
         cap_data.push_back(mem_wdata);
         check("wl_at_we", {16'd0, words_loaded}, 32'(cap_addr.size()));
         check("we_single", {31'd0, prev_we}, 32'd0);
      end
      prev_we = mem_we;
   end

   // Reference model: parse the frame as a byte list
   function automatic void model(input logic [7:0] s[$]);
      int          i;
      int unsigned len;
      logic [7:0]  x;
      exp_addr.delete();
      exp_data.delete();
      exp_done = 1'b0;
      exp_code = 2'd0;
      x = 8'h00;
      i = 0;
      while (s[i] != 8'hA5) i++;
      len = 32'({s[i+2], s[i+1]});
      i += 3;
      if (len > DEPTH) begin
         exp_code = 2'd1;
         return;
      end
      for (int k = 0; k < int'(len); k++) begin
         exp_addr.push_back(BASE + 32'(4 * k));
         exp_data.push_back({s[i+3], s[i+2], s[i+1], s[i]});
         x = x ^ s[i] ^ s[i+1] ^ s[i+2] ^ s[i+3];
         i += 4;
      end
      if (s[i] == x) exp_done = 1'b1;
      else           exp_code = 2'd2;
   endfunction

   function automatic void make_frame(input int len, input bit bad, input int junk);
      logic [7:0]  b;
      logic [7:0]  x;
      logic [15:0] l16;
      frm.delete();
      x   = 8'h00;
      l16 = 16'(len);
      repeat (junk) begin
         b = 8'($urandom);
         if (b == 8'hA5) b = 8'h3C;
         frm.push_back(b);
      end
      frm.push_back(8'hA5);
      frm.push_back(l16[7:0]);
      frm.push_back(l16[15:8]);
      if (len <= DEPTH) begin
         repeat (4 * len) begin
            b = 8'($urandom);
            x ^= b;
            frm.push_back(b);
         end
         frm.push_back(bad ? (x ^ 8'(1 + $urandom_range(254))) : x);
      end
   endfunction

   task automatic check_reset(input string t);
      check({t, ":we"},    {31'd0, mem_we}, 32'd0);
      check({t, ":addr"},  mem_addr, BASE);
      check({t, ":wdata"}, mem_wdata, 32'd0);
      check({t, ":busy"},  {31'd0, busy}, 32'd0);
      check({t, ":done"},  {31'd0, done}, 32'd0);
      check({t, ":error"}, {31'd0, error}, 32'd0);
      check({t, ":code"},  {30'd0, err_code}, 32'd0);
      check({t, ":words"}, {16'd0, words_loaded}, 32'd0);
      check({t, ":hold"},  {31'd0, core_hold}, 32'd1);
   endtask

   task automatic run_frame(input string name, input int max_gap);
      model(frm);
      cap_addr.delete();
      cap_data.delete();
      pulse_start();
      check({name, ":busy_on"}, {31'd0, busy}, 32'd1);
      foreach (frm[i]) begin
         send_byte(frm[i]);
         repeat ($urandom_range(max_gap, 0)) tick();
      end
      repeat (3) tick();
      check({name, ":done"},  {31'd0, done}, {31'd0, exp_done});
      check({name, ":error"}, {31'd0, error}, {31'd0, exp_code != 2'd0});
      check({name, ":code"},  {30'd0, err_code}, {30'd0, exp_code});
      check({name, ":hold"},  {31'd0, core_hold}, {31'd0, !exp_done});
      check({name, ":busy"},  {31'd0, busy}, 32'd0);
      check({name, ":words"}, {16'd0, words_loaded}, 32'(exp_addr.size()));
      check({name, ":nwr"},   32'(cap_addr.size()), 32'(exp_addr.size()));
      for (int k = 0; k < exp_addr.size() && k < cap_addr.size(); k++) begin
         check({name, ":waddr"}, cap_addr[k], exp_addr[k]);
         check({name, ":wdata"}, cap_data[k], exp_data[k]);
      end
      $display("frame %s: bytes=%0d writes=%0d done=%0d err_code=%0d",
               name, frm.size(), cap_addr.size(), done, err_code);
   endtask

   initial begin
      int len;

      // 1. reset values, then mid-clock asynchronous reset after a load
      repeat (2) tick();
      check_reset("rst0");
      rst_n = 1'b1;
      tick();

      // 2. normal two-word load
      frm = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
              8'h93, 8'h00, 8'h10, 8'h00, 8'h90};
      run_frame("normal", 0);
      check("normal:w1data", exp_data.size() > 1 ? exp_data[1] : 32'd0, 32'h0010_0093);

      #2 rst_n = 1'b0;
      #1 check_reset("rst_mid");
      tick();
      rst_n = 1'b1;
      tick();

      // 3. sync hunt and zero length
      frm = '{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h00, 8'h00, 8'h00};
      run_frame("sync_zero", 1);

      // 4. length overflow, error visible on the cycle after LEN_HI
      cap_addr.delete();
      pulse_start();
      send_byte(8'hA5);
      send_byte(8'h1F);
      send_byte(8'h00);
      check("len_ovf:error", {31'd0, error}, 32'd1);
      check("len_ovf:code",  {30'd0, err_code}, 32'd1);
      check("len_ovf:hold",  {31'd0, core_hold}, 32'd1);
      repeat (3) tick();
      check("len_ovf:nwr", 32'(cap_addr.size()), 32'd0);
      $display("frame len_ovf: len=31 err_code=%0d", err_code);

      // 5. bad checksum, then a good reload
      frm = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
              8'h93, 8'h00, 8'h10, 8'h00, 8'h91};
      run_frame("bad_csum", 0);
      frm[11] = 8'h90;
      run_frame("restart", 2);

      // length at the memory depth is accepted
      make_frame(DEPTH, 1'b0, 2);
      run_frame("len_max", 1);

      // 6a. timeout exactly TMO cycles after the last byte
      pulse_start();
      send_byte(8'hA5);
      send_byte(8'h01);
      @(negedge clk);
      repeat (TMO - 2) @(negedge clk);
      check("tmo:early", {31'd0, error}, 32'd0);
      @(negedge clk);
      check("tmo:error", {31'd0, error}, 32'd1);
      check("tmo:code",  {30'd0, err_code}, 32'd3);
      check("tmo:hold",  {31'd0, core_hold}, 32'd1);
      check("tmo:busy",  {31'd0, busy}, 32'd0);
      tick();
      $display("frame timeout: err_code=%0d", err_code);

      // 6b. reset in DATA drops the pending write
      cap_addr.delete();
      pulse_start();
      send_byte(8'hA5);
      send_byte(8'h02);
      send_byte(8'h00);
      send_byte(8'h11);
      send_byte(8'h22);
      send_byte(8'h33);
      send_byte(8'h44);
      check("rst_data:pre_we", {31'd0, mem_we}, 32'd1);
      rst_n = 1'b0;
      #1 check_reset("rst_data");
      tick();
      rst_n = 1'b1;
      send_byte(8'hA5);
      repeat (5) tick();
      check("rst_data:busy", {31'd0, busy}, 32'd0);
      check("rst_data:nwr", 32'(cap_addr.size()), 32'd0);
      $display("frame reset_in_data: writes=%0d", cap_addr.size());

      // random frames
      for (int f = 0; f < 20; f++) begin
         len = ($urandom_range(5) == 0) ? int'($urandom_range(40, 31)) : int'($urandom_range(8));
         make_frame(len, $urandom_range(3) == 0, int'($urandom_range(3)));
         run_frame($sformatf("rnd%0d", f), 3);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
